// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between stopwatch_ctrl and its neighbours: buttons, tick, live digits in;
// gated tick, clear, display digits and run flag out.
interface stopwatch_ctrl_if;
   logic       btn_start;
   logic       btn_lap;
   logic       tick_10Hz;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] hundreds;
   logic [3:0] thousands;
   logic       count_tick;
   logic       count_clr;
   logic [3:0] disp_ones;
   logic [3:0] disp_tens;
   logic [3:0] disp_hundreds;
   logic [3:0] disp_thousands;
   logic       running;

   modport master (
      output btn_start, btn_lap, tick_10Hz, ones, tens, hundreds, thousands,
      input  count_tick, count_clr, disp_ones, disp_tens, disp_hundreds, disp_thousands,
             running
   );

   modport slave (
      input  btn_start, btn_lap, tick_10Hz, ones, tens, hundreds, thousands,
      output count_tick, count_clr, disp_ones, disp_tens, disp_hundreds, disp_thousands,
             running
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap controller: button debounce, tick gating, counter clear, lap freeze.
// Define STOPWATCH_LAP_EN to build the LAP_RUN state and the lap latch.
module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input logic             clk_100MHz,
   input logic             reset,
   stopwatch_ctrl_if.slave bus
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

`ifdef STOPWATCH_LAP_EN
   typedef enum logic [1:0] {StStop, StRun, StLapRun} state_e;
`else
   typedef enum logic [1:0] {StStop, StRun} state_e;
`endif

   // Bit 0 is the start button, bit 1 the lap button.
   logic [1:0]      raw;
   logic [1:0]      meta_q;
   logic [1:0]      sync_q;
   logic [1:0]      level_q;
   logic [1:0]      press_q;
   logic [CntW-1:0] cnt_q [2];

   logic            start_press;
   logic            lap_press;
   logic [15:0]     live;

   state_e          state_q;
   logic            count_tick_q;
   logic            count_clr_q;
   logic            running_q;
   logic [15:0]     disp_q;
`ifdef STOPWATCH_LAP_EN
   logic [15:0]     latch_q;
`endif

   assign raw         = {bus.btn_lap, bus.btn_start};
   assign start_press = press_q[0];
   assign lap_press   = press_q[1];
   assign live        = {bus.thousands, bus.hundreds, bus.tens, bus.ones};

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         meta_q   <= '0;
         sync_q   <= '0;
         level_q  <= '0;
         press_q  <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync_q[i] == level_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               // Differing level held long enough: accept it, pulse only on a press.
               cnt_q[i]   <= '0;
               level_q[i] <= sync_q[i];
               press_q[i] <= sync_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q      <= StStop;
         count_tick_q <= 1'b0;
         count_clr_q  <= 1'b0;
         running_q    <= 1'b0;
         disp_q       <= '0;
`ifdef STOPWATCH_LAP_EN
         latch_q      <= '0;
`endif
      end else begin
         // Gate on the current state so a tick during the exit from STOP is dropped.
         count_tick_q <= bus.tick_10Hz && (state_q != StStop);
         running_q    <= (state_q != StStop);
         count_clr_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         disp_q       <= (state_q == StLapRun) ? latch_q : live;
`else
         disp_q       <= live;
`endif
         case (state_q)
            StStop: begin
               if (start_press) begin
                  state_q <= StRun;
               end else if (lap_press) begin
                  count_clr_q <= 1'b1;
               end
            end
            StRun: begin
               if (start_press) begin
                  state_q <= StStop;
`ifdef STOPWATCH_LAP_EN
               end else if (lap_press) begin
                  state_q <= StLapRun;
                  latch_q <= live;
`endif
               end
            end
`ifdef STOPWATCH_LAP_EN
            StLapRun: begin
               if (start_press) begin
                  state_q <= StStop;
               end else if (lap_press) begin
                  state_q <= StRun;
               end
            end
`endif
            default: state_q <= StStop;
         endcase
      end
   end

   assign bus.count_tick     = count_tick_q;
   assign bus.count_clr      = count_clr_q;
   assign bus.running        = running_q;
   assign bus.disp_ones      = disp_q[3:0];
   assign bus.disp_tens      = disp_q[7:4];
   assign bus.disp_hundreds  = disp_q[11:8];
   assign bus.disp_thousands = disp_q[15:12];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl with a behavioural reference model and directed anchors.
// Honours STOPWATCH_LAP_EN the same way the design does.
module tb_stopwatch_ctrl;

   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .bus        (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_cycle = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, n_cycle);
   endtask

   // Reference model: mode 0 = stopped, 1 = running, 2 = running with lap frozen.
   bit         m_valid = 0;
   int         m_state;
   bit  [15:0] m_latch;
   bit         m_sp, m_lp;
   bit  [1:0]  m_lvl;
   bit  [1:0]  rawq [$];
   bit         e_tick, e_clr, e_run;
   bit  [15:0] e_disp;

   always @(posedge clk) begin
      bit [15:0] live;
      bit [1:0]  newp;
      bit        all_diff;
      n_cycle++;
      if (reset) begin
         m_valid = 1;
         m_state = 0;
         m_latch = '0;
         m_sp = 0;
         m_lp = 0;
         m_lvl = '0;
         e_tick = 0;
         e_clr = 0;
         e_run = 0;
         e_disp = '0;
         rawq.delete();
         for (int k = 0; k < D + 2; k++) rawq.push_back(2'b00);
      end else if (m_valid) begin
         live   = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
         e_tick = bus.tick_10Hz && (m_state != 0);
         e_run  = (m_state != 0);
         e_clr  = (m_state == 0) && m_lp && !m_sp;
         e_disp = (m_state == 2) ? m_latch : live;
         if (m_sp) begin
            m_state = (m_state == 0) ? 1 : 0;
         end else if (m_lp) begin
            if (m_state == 1) begin
`ifdef STOPWATCH_LAP_EN
               m_state = 2;
               m_latch = live;
`endif
            end else if (m_state == 2) begin
               m_state = 1;
            end
         end
         // A level is accepted once the last D synchronized samples all differ from it;
         // the synchronized sample seen at this edge is the raw value two edges back.
         for (int b = 0; b < 2; b++) begin
            all_diff = 1;
            for (int k = 1; k <= D; k++) if (rawq[k][b] == m_lvl[b]) all_diff = 0;
            newp[b] = all_diff && !m_lvl[b];
            if (all_diff) m_lvl[b] = ~m_lvl[b];
         end
         m_sp = newp[0];
         m_lp = newp[1];
         void'(rawq.pop_front());
         rawq.push_back({bus.btn_lap, bus.btn_start});
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("outputs{tick,clr,run,disp}",
               {13'd0, bus.count_tick, bus.count_clr, bus.running,
                bus.disp_thousands, bus.disp_hundreds, bus.disp_tens, bus.disp_ones},
               {13'd0, e_tick, e_clr, e_run, e_disp});
      end
   end

   // Pulse tallies sampled before each edge updates the outputs.
   int n_tick = 0, n_clr = 0, n_rise = 0;
   logic run_prev = 1'b0;
   always @(posedge clk) begin
      if (bus.count_tick === 1'b1) n_tick++;
      if (bus.count_clr === 1'b1) n_clr++;
      if (bus.running === 1'b1 && run_prev === 1'b0) n_rise++;
      run_prev <= bus.running;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_digits(input logic [15:0] v);
      {bus.thousands, bus.hundreds, bus.tens, bus.ones} = v;
   endtask

   task automatic press(input bit start, input bit lap);
      if (start) bus.btn_start = 1'b1;
      if (lap) bus.btn_lap = 1'b1;
      cyc(D + 6);
      bus.btn_start = 1'b0;
      bus.btn_lap = 1'b0;
      cyc(D + 6);
   endtask

   task automatic disp_now(output logic [15:0] v);
      v = {bus.disp_thousands, bus.disp_hundreds, bus.disp_tens, bus.disp_ones};
   endtask

   initial begin
      int base;
      logic [15:0] dv;
      int hold_s, hold_l;
      bus.btn_start = 1'b0;
      bus.btn_lap   = 1'b0;
      bus.tick_10Hz = 1'b0;
      set_digits(16'h0000);
      cyc(2);
      reset = 1'b0;
      check("reset running", {31'd0, bus.running}, 32'd0);
      check("reset count_clr", {31'd0, bus.count_clr}, 32'd0);
      check("reset count_tick", {31'd0, bus.count_tick}, 32'd0);
      disp_now(dv);
      check("reset disp", {16'd0, dv}, 32'd0);

      // Bouncy start button, then a clean hold.
      set_digits(16'h1240);
      for (int i = 0; i < 20; i++) begin
         bus.btn_start = ((i / 2) % 2 == 0);
         cyc(1);
      end
      check("bounce no early run", {31'd0, bus.running}, 32'd0);
      bus.btn_start = 1'b1;
      cyc(D + 6);
      check("bounce running", {31'd0, bus.running}, 32'd1);
      check("bounce single press", n_rise, 1);
      disp_now(dv);
      check("run disp live", {16'd0, dv}, 32'h1240);
      bus.btn_start = 1'b0;
      cyc(D + 6);

      // Tick gating while running.
      base = n_tick;
      for (int i = 0; i < 3; i++) begin
         bus.tick_10Hz = 1'b1;
         cyc(1);
         bus.tick_10Hz = 1'b0;
         cyc(2);
      end
      cyc(2);
      check("gated ticks", n_tick - base, 3);

      // Lap freeze then release.
      press(0, 1);
      set_digits(16'h1300);
      cyc(2);
      disp_now(dv);
`ifdef STOPWATCH_LAP_EN
      check("lap frozen disp", {16'd0, dv}, 32'h1240);
`else
      check("lap ignored disp", {16'd0, dv}, 32'h1300);
`endif
      check("lap still running", {31'd0, bus.running}, 32'd1);
      press(0, 1);
      disp_now(dv);
      check("lap released disp", {16'd0, dv}, 32'h1300);

      // Stop, then a tick must not pass.
      press(1, 0);
      check("stopped", {31'd0, bus.running}, 32'd0);
      base = n_tick;
      bus.tick_10Hz = 1'b1;
      cyc(1);
      bus.tick_10Hz = 1'b0;
      cyc(2);
      check("tick blocked in stop", n_tick - base, 0);

      // Clear in STOP.
      base = n_clr;
      press(0, 1);
      check("clear pulse count", n_clr - base, 1);
      check("clear stays stopped", {31'd0, bus.running}, 32'd0);

      // Simultaneous presses while running.
      press(1, 0);
      check("restart running", {31'd0, bus.running}, 32'd1);
      base = n_clr;
      set_digits(16'h0517);
      press(1, 1);
      check("simultaneous stops", {31'd0, bus.running}, 32'd0);
      check("simultaneous no clear", n_clr - base, 0);
      disp_now(dv);
      check("simultaneous disp live", {16'd0, dv}, 32'h0517);

      // Reset in the middle of a lap.
      press(1, 0);
      press(0, 1);
      set_digits(16'h0999);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("midreset running", {31'd0, bus.running}, 32'd0);
      disp_now(dv);
      check("midreset disp", {16'd0, dv}, 32'd0);
      cyc(2);

      // Randomized phase.
      hold_s = 0;
      hold_l = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold_s == 0) begin
            bus.btn_start = $urandom_range(0, 1);
            hold_s = (bus.btn_start) ? $urandom_range(1, 14) : $urandom_range(1, 30);
            if ($urandom_range(0, 7) == 0) begin
               bus.btn_lap = bus.btn_start;
               hold_l = hold_s;
            end
         end
         if (hold_l == 0) begin
            bus.btn_lap = $urandom_range(0, 1);
            hold_l = (bus.btn_lap) ? $urandom_range(1, 14) : $urandom_range(1, 30);
         end
         hold_s--;
         hold_l--;
         bus.tick_10Hz = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) set_digits(16'($urandom));
         reset = ($urandom_range(0, 499) == 0);
         cyc(1);
      end
      reset = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
